mult32x32: RTL and testbench

- Sequential unsigned 32x32 -> 64-bit multiplier built around one 8x16 partial-product multiplier.
- Computes the product over 8 clock cycles: 4 bytes of a, times 2 halfwords of b.
- Accumulates the shifted partial products into a 64-bit product register.
- Used as a small-area arithmetic block with a simple start/busy handshake.

---
 rtl/mult32x32_pkg.sv | 25 ++
 rtl/mult32x32_arith.sv | 80 ++++++++
 rtl/mult32x32.sv | 82 ++++++++
 tb/tb_mult32x32.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/mult32x32_pkg.sv
// rtl/mult32x32_pkg.sv - shared types and widths for the mult32x32 sequential multiplier
// Purpose: step-state enum and fixed widths used by the top FSM and the datapath.
// Ports: none (package).
package mult32x32_pkg;

  localparam int OPERAND_W = 32;
  localparam int PRODUCT_W = 64;
  localparam int A_SEL_W   = 2;
  localparam int B_SEL_W   = 1;
  localparam int PP_W      = 24;

  // P0..P7 are encoded as 1..8, so the step index k is state - 1.
  typedef enum logic [3:0] {
    IDLE = 4'd0,
    P0   = 4'd1,
    P1   = 4'd2,
    P2   = 4'd3,
    P3   = 4'd4,
    P4   = 4'd5,
    P5   = 4'd6,
    P6   = 4'd7,
    P7   = 4'd8
  } state_e;

endpackage

// File: rtl/mult32x32_arith.sv
// rtl/mult32x32_arith.sv - operand registers, 8x16 partial product and 64-bit accumulator
// Purpose: latch operands, form a_byte*b_half, shift into place and accumulate.
// Ports:
//   clk_i       rising-edge clock
//   rst_ni      asynchronous active-low reset
//   clr_prod_i  latch a_i/b_i and clear the product register
//   upd_prod_i  add the current shifted partial product to the product register
//   a_sel_i     which byte of the latched a (0..3)
//   b_sel_i     which halfword of the latched b (0..1)
//   a_i, b_i    operands presented at start
//   product_o   product register
module mult32x32_arith
  import mult32x32_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clr_prod_i,
  input  logic                 upd_prod_i,
  input  logic [A_SEL_W-1:0]   a_sel_i,
  input  logic [B_SEL_W-1:0]   b_sel_i,
  input  logic [OPERAND_W-1:0] a_i,
  input  logic [OPERAND_W-1:0] b_i,
  output logic [PRODUCT_W-1:0] product_o
);

  logic [OPERAND_W-1:0] a_q, a_d;
  logic [OPERAND_W-1:0] b_q, b_d;
  logic [PRODUCT_W-1:0] prod_q, prod_d;
  logic [7:0]           a_byte;
  logic [15:0]          b_half;
  logic [PP_W-1:0]      pp;
  logic [5:0]           shamt;
  logic [PRODUCT_W-1:0] pp_shift;

  always_comb begin
    a_byte = a_q[7:0];
    case (a_sel_i)
      2'd0:    a_byte = a_q[7:0];
      2'd1:    a_byte = a_q[15:8];
      2'd2:    a_byte = a_q[23:16];
      default: a_byte = a_q[31:24];
    endcase
  end

  assign b_half = b_sel_i[0] ? b_q[31:16] : b_q[15:0];

  assign pp = {16'b0, a_byte} * {8'b0, b_half};

  // Shift by 8*a_sel + 16*b_sel; the largest placement (24 bits at 40) still fits in 64.
  assign shamt    = {1'b0, a_sel_i, 3'b000} + {1'b0, b_sel_i, 4'b0000};
  assign pp_shift = {40'b0, pp} << shamt;

  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    prod_d = prod_q;
    if (clr_prod_i) begin
      a_d    = a_i;
      b_d    = b_i;
      prod_d = '0;
    end else if (upd_prod_i) begin
      prod_d = prod_q + pp_shift;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_q    <= '0;
      b_q    <= '0;
      prod_q <= '0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      prod_q <= prod_d;
    end
  end

  assign product_o = prod_q;

endmodule

// File: rtl/mult32x32.sv
// rtl/mult32x32.sv - sequential unsigned 32x32->64 multiplier with start/busy handshake
// Purpose: step FSM (IDLE, P0..P7) sequencing the 8x16 datapath over 8 cycles.
// Ports:
//   clk      rising-edge clock
//   reset    asynchronous active-low reset
//   start    request, sampled while idle
//   a, b     unsigned operands, latched at the accepted start
//   busy     registered, high for exactly 8 cycles per job
//   product  accumulated result, final when busy falls
module mult32x32
  import mult32x32_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [OPERAND_W-1:0] a,
  input  logic [OPERAND_W-1:0] b,
  output logic                 busy,
  output logic [PRODUCT_W-1:0] product
);

  state_e               state_q, state_d;
  logic                 busy_q, busy_d;
  logic                 clr_prod, upd_prod;
  logic [2:0]           step;
  logic [A_SEL_W-1:0]   a_sel;
  logic [B_SEL_W-1:0]   b_sel;

  // Step k = state - 1: low two bits pick the a byte, bit 2 picks the b half.
  assign step  = 3'(state_q - 4'd1);
  assign a_sel = step[1:0];
  assign b_sel = step[2:2];

  always_comb begin
    state_d  = state_q;
    clr_prod = 1'b0;
    upd_prod = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          clr_prod = 1'b1;
          state_d  = P0;
        end
      end
      P0, P1, P2, P3, P4, P5, P6: begin
        upd_prod = 1'b1;
        state_d  = state_e'(state_q + 4'd1);
      end
      P7: begin
        upd_prod = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
    end
  end

  assign busy = busy_q;

  mult32x32_arith u_arith (
    .clk_i      (clk),
    .rst_ni     (reset),
    .clr_prod_i (clr_prod),
    .upd_prod_i (upd_prod),
    .a_sel_i    (a_sel),
    .b_sel_i    (b_sel),
    .a_i        (a),
    .b_i        (b),
    .product_o  (product)
  );

endmodule

// File: tb/tb_mult32x32.sv
// tb/tb_mult32x32.sv - self-checking bench for mult32x32
module tb_mult32x32;

  logic        clk = 1'b0;
  logic        reset;
  logic        start = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy;
  logic [63:0] product;

  int checks = 0;
  int errors = 0;

  mult32x32 dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .product (product)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Model: a job accepted while idle lasts 8 cycles and ends with product = a*b.
  int          m_cnt = 0;
  logic [63:0] m_prod = '0;
  logic [31:0] m_a = '0;
  logic [31:0] m_b = '0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_cnt  <= 0;
      m_prod <= '0;
    end else if (m_cnt == 0) begin
      if (start) begin
        m_a    <= a;
        m_b    <= b;
        m_cnt  <= 8;
        m_prod <= '0;
      end
    end else begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) m_prod <= 64'(m_a) * 64'(m_b);
    end
  end

  always @(negedge clk) begin
    chk("cmp_busy", {63'b0, busy}, {63'b0, (m_cnt != 0)});
    if (m_cnt == 0) chk("cmp_product_idle", product, m_prod);
    if (m_cnt == 8) chk("cmp_product_cleared", product, 64'd0);
  end

  // Starts a job, optionally disturbs inputs mid-flight, counts busy cycles, checks result.
  task automatic job(input logic [31:0] ta, input logic [31:0] tb_v,
                     input logic [63:0] exp, input string nm, input bit disturb);
    int n;
    @(posedge clk); #1;
    a = ta; b = tb_v; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (busy && n < 20) begin
      if (disturb && n == 2) begin
        a = 32'hDEADBEEF; b = 32'h13579BDF; start = 1'b1;
      end
      if (disturb && n == 3) start = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    chk({nm, "_busy_cycles"}, 64'(n), 64'd8);
    chk({nm, "_product"}, product, exp);
  endtask

  initial begin
    reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("reset_busy", {63'b0, busy}, 64'd0);
    chk("reset_product", product, 64'd0);
    reset = 1'b1;

    job(32'd207363151, 32'd206950149, 64'd42913834996559499, "dec", 1'b0);
    job(32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001, "max", 1'b0);
    job(32'd0, 32'h12345678, 64'd0, "zero", 1'b0);
    job(32'd1, 32'h89ABCDEF, 64'h0000000089ABCDEF, "one", 1'b0);
    job(32'h12345678, 32'h9ABCDEF0, 64'h0B00EA4E242D2080, "disturb", 1'b1);

    // idle holds the result indefinitely
    repeat (5) @(posedge clk);
    #1;
    chk("idle_hold", product, 64'h0B00EA4E242D2080);

    // reset in the 4th busy cycle aborts immediately
    @(posedge clk); #1;
    a = 32'd207363151; b = 32'd206950149; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("pre_abort_busy", {63'b0, busy}, 64'd1);
    #1;
    reset = 1'b0;
    #1;
    chk("abort_busy", {63'b0, busy}, 64'd0);
    chk("abort_product", product, 64'd0);
    @(posedge clk); #2;
    reset = 1'b1;
    job(32'd207363151, 32'd206950149, 64'd42913834996559499, "after_reset", 1'b0);

    // start held high: 8 busy, 1 idle showing the result, 8 busy, 1 idle
    @(posedge clk); #1;
    a = 32'd3; b = 32'd5; start = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      @(posedge clk); #1;
      if (k == 9 || k == 18) begin
        chk($sformatf("b2b_idle_%0d", k), {63'b0, busy}, 64'd0);
        chk($sformatf("b2b_product_%0d", k), product, 64'd15);
      end else begin
        chk($sformatf("b2b_busy_%0d", k), {63'b0, busy}, 64'd1);
      end
      if (k == 18) start = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("final_idle", {63'b0, busy}, 64'd0);
    chk("final_product", product, 64'd15);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
